uart_echo_fifo: RTL and testbench

Buffered UART echo core between the byte receiver and byte sender instances. Received words are pushed into a parametrised circular FIFO and replayed to the sender in order, so back-to-back input no longer loses bytes while the sender is busy. It reports FIFO level and a sticky overflow flag, which drives the board LED.

---
 rtl/uart_echo_fifo.sv | 110 +++++++++++
 tb/tb_uart_echo_fifo.sv | 136 +++++++++++++
 2 files changed

// File: rtl/uart_echo_fifo.sv
// uart_echo_fifo: buffers received UART words in a circular FIFO and replays them to the sender with a guard gap.
// Define UART_ECHO_STATS_EN to add saturating rx/tx/drop counters.
module uart_echo_fifo #(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 16,
  parameter int GAP_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        rx_data,
  input  logic                     rx_valid,
  input  logic                     tx_ready,
  output logic [DATA_W-1:0]        tx_data,
  output logic                     tx_enable,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     led
`ifdef UART_ECHO_STATS_EN
  ,
  output logic [15:0]              rx_count,
  output logic [15:0]              tx_count,
  output logic [15:0]              drop_count
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);
  typedef enum logic {IDLE, GAP} state_e;
  state_e state_q, state_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [LW-1:0] level_q, level_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic tx_en_q, tx_en_d, ovf_q, ovf_d, push_ok, drop, pop;
  always_comb begin
    push_ok   = rx_valid && (level_q != LW'(DEPTH));
    drop      = rx_valid && (level_q == LW'(DEPTH));
    pop       = (state_q == IDLE) && (level_q != '0) && tx_ready;
    state_d   = state_q;
    gap_d     = gap_q;
    tx_en_d   = 1'b0;
    tx_data_d = tx_data_q;
    if (pop) begin
      state_d   = GAP;
      gap_d     = GW'(GAP_CYCLES);
      tx_en_d   = 1'b1;
      tx_data_d = mem_q[rd_q];
    end else if (state_q == GAP) begin
      gap_d   = gap_q - GW'(1);
      state_d = (gap_q == GW'(1)) ? IDLE : GAP;
    end
    rd_d    = pop ? rd_q + AW'(1) : rd_q;
    wr_d    = push_ok ? wr_q + AW'(1) : wr_q;
    level_d = (push_ok && !pop) ? level_q + LW'(1) :
              (!push_ok && pop) ? level_q - LW'(1) : level_q;
    ovf_d   = ovf_q || drop;
  end
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= rx_data;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rd_q      <= '0;
      wr_q      <= '0;
      level_q   <= '0;
      gap_q     <= '0;
      tx_data_q <= '0;
      tx_en_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      level_q   <= level_d;
      gap_q     <= gap_d;
      tx_data_q <= tx_data_d;
      tx_en_q   <= tx_en_d;
      ovf_q     <= ovf_d;
    end
  end
  assign tx_data   = tx_data_q;
  assign tx_enable = tx_en_q;
  assign level     = level_q;
  assign overflow  = ovf_q;
  assign led       = ovf_q;
`ifdef UART_ECHO_STATS_EN
  logic [15:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d, drop_cnt_q, drop_cnt_d;
  always_comb begin
    rx_cnt_d   = (push_ok && rx_cnt_q != 16'hFFFF) ? rx_cnt_q + 16'd1 : rx_cnt_q;
    tx_cnt_d   = (pop && tx_cnt_q != 16'hFFFF) ? tx_cnt_q + 16'd1 : tx_cnt_q;
    drop_cnt_d = (drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt_q   <= '0;
      tx_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      rx_cnt_q   <= rx_cnt_d;
      tx_cnt_q   <= tx_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end
  assign rx_count   = rx_cnt_q;
  assign tx_count   = tx_cnt_q;
  assign drop_count = drop_cnt_q;
`endif
endmodule

// File: tb/tb_uart_echo_fifo.sv
// tb_uart_echo_fifo: random and directed stimulus against a queue-based model of the echo FIFO.
module tb_uart_echo_fifo;
  localparam int DEPTH = 16;
  localparam int GAP   = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] rx_data = '0;
  logic rx_valid = 1'b0, tx_ready = 1'b0;
  logic [7:0] tx_data;
  logic tx_enable, overflow, led;
  logic [4:0] level;
`ifdef UART_ECHO_STATS_EN
  logic [15:0] rx_count, tx_count, drop_count;
`endif
  uart_echo_fifo #(.DATA_W(8), .DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .tx_enable(tx_enable), .level(level), .overflow(overflow), .led(led)
`ifdef UART_ECHO_STATS_EN
    , .rx_count(rx_count), .tx_count(tx_count), .drop_count(drop_count)
`endif
  );
  always #5 clk = ~clk;
  int total = 0, passed = 0, cyc = 0, last_tx = -100, pk = 0;
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
  endtask
  // Model: a word queue, a sticky drop flag, and the timestamp of the last start pulse.
  logic [7:0] mq[$];
  logic [7:0] mdata = '0;
  bit men = 0, movf = 0, snd, full;
  typedef struct {int c; logic [7:0] d;} ev_t;
  ev_t evs[$];
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      mq.delete(); movf = 0; mdata = '0; men = 0; last_tx = -100;
    end else begin
      snd  = mq.size() > 0 && tx_ready && (cyc - last_tx > GAP);
      full = mq.size() == DEPTH;
      men  = snd;
      if (snd) begin mdata = mq.pop_front(); last_tx = cyc; end
      if (rx_valid) begin
        if (full) movf = 1;
        else mq.push_back(rx_data);
      end
    end
    #1;
    chk("tx_enable", int'(tx_enable), int'(men));
    chk("tx_data", int'(tx_data), int'(mdata));
    chk("level", int'(level), mq.size());
    chk("overflow", int'(overflow), int'(movf));
    chk("led", int'(led), int'(movf));
    if (int'(level) > pk) pk = int'(level);
    if (tx_enable) evs.push_back('{cyc, tx_data});
  end
  task automatic step(input bit v, input logic [7:0] d, input bit r);
    rx_valid = v; rx_data = d; tx_ready = r;
    @(negedge clk);
  endtask
  initial begin
    int p;
    repeat (3) @(negedge clk);
    chk("reset_level", int'(level), 0);
    chk("reset_overflow", int'(overflow), 0);
    chk("reset_tx_enable", int'(tx_enable), 0);
    rst_n = 1'b1;
    repeat (2) step(0, 8'h00, 1);
    evs.delete();
    step(1, 8'h41, 1);
    p = cyc;
    repeat (5) step(0, 8'h00, 1);
    chk("single_count", evs.size(), 1);
    chk("single_data", int'(evs[0].d), 'h41);
    chk("single_latency", evs[0].c - p, 1);
    chk("single_level", int'(level), 0);
    chk("single_overflow", int'(overflow), 0);
    evs.delete(); pk = 0;
    for (int i = 1; i <= 5; i++) step(1, 8'(i), 1);
    repeat (16) step(0, 8'h00, 1);
    chk("burst_count", evs.size(), 5);
    for (int i = 0; i < 5; i++) chk("burst_data", int'(evs[i].d), i + 1);
    for (int i = 1; i < 5; i++) chk("burst_spacing", evs[i].c - evs[i-1].c, GAP + 1);
    chk("burst_peak_bounded", int'(pk <= 4), 1);
    evs.delete();
    for (int i = 0; i < 17; i++) step(1, 8'(8'h80 + i), 0);
    chk("full_level", int'(level), 16);
    chk("full_overflow", int'(overflow), 1);
    chk("full_led", int'(led), 1);
    step(1, 8'hEE, 1);
    chk("full_push_pop_level", int'(level), 15);
    chk("full_push_pop_overflow", int'(overflow), 1);
    repeat (60) step(0, 8'h00, 1);
    chk("overflow_drain_count", evs.size(), 16);
    for (int i = 0; i < 16; i++) chk("overflow_drain_data", int'(evs[i].d), 'h80 + i);
    repeat (3) step(1, 8'h33, 0);
    step(1, 8'h34, 1);
    chk("lvl3_push_pop", int'(level), 3);
    repeat (15) step(0, 8'h00, 1);
    evs.delete();
    for (int i = 0; i < 40; i++) begin
      step(1, 8'(i * 7 + 3), 1);
      if (i % 3 == 2) repeat (6) step(0, 8'h00, 1);
    end
    repeat (130) step(0, 8'h00, 1);
    chk("wrap_count", evs.size(), 40);
    for (int i = 0; i < 40; i++) chk("wrap_data", int'(evs[i].d), (i * 7 + 3) % 256);
    repeat (600) step(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 3) != 0);
    repeat (60) step(0, 8'h00, 1);
    repeat (6) step(1, 8'h60, 0);
    step(1, 8'h61, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_tx_enable", int'(tx_enable), 0);
    chk("async_level", int'(level), 0);
    chk("async_overflow", int'(overflow), 0);
    chk("async_led", int'(led), 0);
`ifdef UART_ECHO_STATS_EN
    chk("async_rx_count", int'(rx_count), 0);
    chk("async_tx_count", int'(tx_count), 0);
    chk("async_drop_count", int'(drop_count), 0);
`endif
    @(negedge clk);
    step(0, 8'h00, 1);
    rst_n = 1'b1;
    evs.delete();
    repeat (8) step(0, 8'h00, 1);
    chk("post_reset_silent", evs.size(), 0);
    step(1, 8'h5A, 1);
    repeat (4) step(0, 8'h00, 1);
    chk("post_reset_count", evs.size(), 1);
    chk("post_reset_data", int'(evs[0].d), 'h5A);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
